microseq_pc: RTL and testbench
==============================

Name: microseq_pc

Overview:
- Registered microprogram sequencer. Holds the micro-PC (upc) and computes the next control-store address each cycle.
- Generalises the combinational next-address logic (na / IR dispatch / zero-flag branch) to:
  - parametrised address width and flag count;
  - selectable condition and polarity;
  - a micro-subroutine return stack with overflow/underflow detection.
- Sits between the control-store ROM (addressed by upc_next for synchronous ROMs, or upc for asynchronous ROMs) and the datapath flags.

Parameters:
- AW, 5, micro-address width (also opcode/dispatch width).
- NFLAGS, 4, number of condition flag inputs (flag 0 = Z).
- SDEPTH, 4, return-stack depth (>=1).
- FETCH_ADDR, 0, micro-address of FETCH1; reset/abort/error target.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = hold all state.
- abort  in  1  synchronous flush (priority over en).
- ctrl  in  3  sequencing op from current microinstruction.
- na  in  AW  next/target address field.
- opcode  in  AW  IR opcode field (dispatch address).
- flags  in  NFLAGS  datapath condition flags.
- cond_sel  in  max(1,$clog2(NFLAGS))  selects flags[cond_sel].
- cond_pol  in  1  condition true when flags[cond_sel]==cond_pol.
- upc  out  AW  current micro-PC (registered).
- upc_next  out  AW  combinational value upc takes at next enabled edge.
- sp  out  $clog2(SDEPTH+1)  stack occupancy.
- stk_ovf  out  1  sticky: push attempted when full.
- stk_unf  out  1  sticky: pop attempted when empty.
- illegal  out  1  sticky: reserved ctrl code executed.

Behaviour:
- Reset (async, rst_n=0): upc=FETCH_ADDR, sp=0, stk_ovf=stk_unf=illegal=0, stack contents don't-care.
- Edge with abort=1: upc=FETCH_ADDR, sp=0, all three sticky flags cleared; en ignored.
- Edge with en=0 and abort=0: all registers hold; upc_next still reflects the decode.
- Edge with en=1: upc<=upc_next. Latency: 1 cycle from ctrl/na/flags to upc. inc = (upc+1) mod 2^AW, so the top address wraps to 0.
- ctrl encoding:
  - 000 NEXT: upc_next=na.
  - 001 DISPATCH: upc_next=opcode.
  - 010 CJUMP: cond true -> na; else inc.
  - 011 CALL: push inc; upc_next=na.
  - 100 RET: pop; upc_next=top of stack.
  - 101 CDISPATCH: cond true -> opcode; else na. This generalises the JMPNZ dispatch, where the Z condition redirects to an alternate entry.
  - 110, 111: reserved (see Optional Feature).
- CALL with sp==SDEPTH: no push, sp unchanged, upc_next=na, stk_ovf<=1.
- RET with sp==0: upc_next=FETCH_ADDR, stk_unf<=1.
- Reserved code (feature disabled): upc_next=FETCH_ADDR, illegal<=1.
- Sticky flags clear only on reset or abort.
- Stack and flag updates occur only on enabled edges. When en=0, upc_next still shows the intended target, so RET shows the current top or FETCH_ADDR.
- cond_sel >= NFLAGS: condition is false.
- Fully synchronous single-clock design; no X propagation from na when ctrl is not NEXT/CJUMP/CALL/CDISPATCH. The bench drives na=x for DISPATCH.

Optional Feature:
- Macro MICROSEQ_LOOP_EN adds an AW-bit loop counter lcnt (reset/abort -> 0) and uses the reserved codes:
  - 110 LDCNT: lcnt<=na; upc_next=inc.
  - 111 LOOP: if lcnt!=0, lcnt<=lcnt-1 and upc_next=na; else upc_next=inc.
- LDCNT and LOOP do not touch the stack. Body executes lcnt+1 times.
- Without the macro: 110/111 are reserved, no counter logic is synthesised, and illegal is set as above.

Test Plan:
- Reset/fetch: rst_n=0 mid-run with upc=17 -> upc=0 immediately (async, before next edge); then NEXT na=1 -> upc=1.
- Dispatch: DISPATCH opcode=21, na=x -> upc=21; NEXT 22, NEXT 23, NEXT 0 -> upc sequence 22,23,0.
- Conditional:
  - CDISPATCH opcode=10, na=13, cond_sel=0, cond_pol=0, Z=0 -> upc=10; with Z=1 -> upc=13.
  - CJUMP at upc=31, cond false -> upc=0 (wrap).
- Stack: upc=5 CALL na=20 -> upc=20, sp=1; RET -> upc=6, sp=0; RET again -> upc=0, stk_unf=1; five CALLs with SDEPTH=4 -> sp=4, stk_ovf=1; abort -> flags 0, sp=0, upc=0.
- Stall: en=0 for 3 cycles with ctrl=CALL -> upc, sp unchanged, upc_next=na.
- Loop (macro defined): LDCNT na=2 at upc=3, then LOOP na=4 at upc=4 -> body at 4 executed 3 times, then upc=5. Without macro: ctrl=110 -> upc=0, illegal=1.

Source files
------------

// File: rtl/microseq_pc.sv
// microseq_pc: registered microprogram sequencer.
// Holds the micro-PC and computes the next control-store address from the
// current sequencing op, the next-address field, the IR opcode and a
// selectable datapath flag. A small return stack supports micro-subroutines.
// Overflow, underflow and illegal-op conditions latch into sticky flags.
// upc_next is the address upc takes at the next enabled edge, so a
// synchronous control-store ROM can be addressed with it directly.
//
// Optional build macro: MICROSEQ_LOOP_EN
//   When defined, adds an internal loop counter. Ops 110 (LDCNT) and
//   111 (LOOP) become legal. Without it, both codes are reserved: they
//   redirect to FETCH_ADDR and set illegal.

module microseq_pc #(
    parameter int AW         = 5,
    parameter int NFLAGS     = 4,
    parameter int SDEPTH     = 4,
    parameter int FETCH_ADDR = 0,
    localparam int CSW       = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int SPW       = $clog2(SDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              abort,
    input  logic [2:0]        ctrl,
    input  logic [AW-1:0]     na,
    input  logic [AW-1:0]     opcode,
    input  logic [NFLAGS-1:0] flags,
    input  logic [CSW-1:0]    cond_sel,
    input  logic              cond_pol,
    output logic [AW-1:0]     upc,
    output logic [AW-1:0]     upc_next,
    output logic [SPW-1:0]    sp,
    output logic              stk_ovf,
    output logic              stk_unf,
    output logic              illegal
);

    typedef enum logic [2:0] {
        OP_NEXT      = 3'b000,
        OP_DISPATCH  = 3'b001,
        OP_CJUMP     = 3'b010,
        OP_CALL      = 3'b011,
        OP_RET       = 3'b100,
        OP_CDISPATCH = 3'b101,
        OP_LDCNT     = 3'b110,
        OP_LOOP      = 3'b111
    } op_e;

    localparam logic [AW-1:0]  FETCH_A = AW'(FETCH_ADDR);
    localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

    logic [AW-1:0] stack [SDEPTH];
    logic [AW-1:0] inc;
    logic [AW-1:0] top;
    logic          cond;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;
    logic          set_ill;
    logic          adv;

`ifdef MICROSEQ_LOOP_EN
    logic [AW-1:0] lcnt;
    logic [AW-1:0] lcnt_next;
`endif

    // Sequential increment wraps from the top address to 0.
    assign inc       = upc + 1'b1;
    assign stk_full  = (sp == SP_FULL);
    assign stk_empty = (sp == '0);
    assign adv       = en && !abort;

    // Condition: selected flag matches polarity; out-of-range selects are false.
    always_comb begin
        cond = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (cond_sel == CSW'(i)) begin
                cond = (flags[i] == cond_pol);
            end
        end
    end

    // Top-of-stack read: entry sp-1, chosen by compare to avoid width games.
    always_comb begin
        top = FETCH_A;
        for (int i = 0; i < SDEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                top = stack[i];
            end
        end
    end

    // Next-address decode and side-effect requests for the current op.
    always_comb begin
        upc_next = upc;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        set_ill  = 1'b0;
`ifdef MICROSEQ_LOOP_EN
        lcnt_next = lcnt;
`endif
        case (op_e'(ctrl))
            OP_NEXT:      upc_next = na;
            OP_DISPATCH:  upc_next = opcode;
            OP_CJUMP:     upc_next = cond ? na : inc;
            OP_CALL: begin
                // A full stack drops the return address but still jumps.
                upc_next = na;
                if (stk_full) begin
                    set_ovf = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            OP_RET: begin
                // Returning with nothing stacked restarts at fetch.
                if (stk_empty) begin
                    upc_next = FETCH_A;
                    set_unf  = 1'b1;
                end else begin
                    upc_next = top;
                    pop      = 1'b1;
                end
            end
            OP_CDISPATCH: upc_next = cond ? opcode : na;
`ifdef MICROSEQ_LOOP_EN
            OP_LDCNT: begin
                lcnt_next = na;
                upc_next  = inc;
            end
            OP_LOOP: begin
                // Body runs lcnt+1 times: branch back while count is nonzero.
                if (lcnt != '0) begin
                    lcnt_next = lcnt - 1'b1;
                    upc_next  = na;
                end else begin
                    upc_next  = inc;
                end
            end
`else
            OP_LDCNT, OP_LOOP: begin
                upc_next = FETCH_A;
                set_ill  = 1'b1;
            end
`endif
            default: begin
                upc_next = FETCH_A;
                set_ill  = 1'b1;
            end
        endcase
    end

    // Control registers: reset and abort force fetch and clear sticky state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc     <= FETCH_A;
            sp      <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            illegal <= 1'b0;
        end else if (abort) begin
            upc     <= FETCH_A;
            sp      <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            illegal <= 1'b0;
        end else if (en) begin
            upc <= upc_next;
            if (push) begin
                sp <= sp + 1'b1;
            end else if (pop) begin
                sp <= sp - 1'b1;
            end
            stk_ovf <= stk_ovf | set_ovf;
            stk_unf <= stk_unf | set_unf;
            illegal <= illegal | set_ill;
        end
    end

    // Return-stack storage: contents are don't-care after reset, so no reset.
    always_ff @(posedge clk) begin
        if (adv && push) begin
            for (int i = 0; i < SDEPTH; i++) begin
                if (sp == SPW'(i)) begin
                    stack[i] <= inc;
                end
            end
        end
    end

`ifdef MICROSEQ_LOOP_EN
    // Loop counter: cleared by reset/abort, updated only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt <= '0;
        end else if (abort) begin
            lcnt <= '0;
        end else if (en) begin
            lcnt <= lcnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_microseq_pc.sv
// tb_microseq_pc: directed-vector bench for microseq_pc (AW=5, NFLAGS=4,
// SDEPTH=4, FETCH_ADDR=0). Each scenario task drives ops and compares
// against hand-computed addresses.

module tb_microseq_pc;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       abort;
    logic [2:0] ctrl;
    logic [4:0] na;
    logic [4:0] opcode;
    logic [3:0] flags;
    logic [1:0] cond_sel;
    logic       cond_pol;
    logic [4:0] upc;
    logic [4:0] upc_next;
    logic [2:0] sp;
    logic       stk_ovf;
    logic       stk_unf;
    logic       illegal;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] C_NEXT  = 3'b000;
    localparam logic [2:0] C_DISP  = 3'b001;
    localparam logic [2:0] C_CJUMP = 3'b010;
    localparam logic [2:0] C_CALL  = 3'b011;
    localparam logic [2:0] C_RET   = 3'b100;
    localparam logic [2:0] C_CDISP = 3'b101;
    localparam logic [2:0] C_R6    = 3'b110;
    localparam logic [2:0] C_R7    = 3'b111;

    microseq_pc #(.AW(5), .NFLAGS(4), .SDEPTH(4), .FETCH_ADDR(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .abort    (abort),
        .ctrl     (ctrl),
        .na       (na),
        .opcode   (opcode),
        .flags    (flags),
        .cond_sel (cond_sel),
        .cond_pol (cond_pol),
        .upc      (upc),
        .upc_next (upc_next),
        .sp       (sp),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf),
        .illegal  (illegal)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; sample 1 unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [4:0] a);
        ctrl = c;
        na   = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; abort = 1'b0;
        ctrl = C_NEXT; na = '0; opcode = '0; flags = '0;
        cond_sel = '0; cond_pol = 1'b0;
        cycle(); cycle();
        n_vec++;
        if (upc !== 5'd0) begin n_err++; $display("FAIL reset_upc got %0d exp 0", upc); end
        n_vec++;
        if (sp !== 3'd0) begin n_err++; $display("FAIL reset_sp got %0d exp 0", sp); end
        n_vec++;
        if ({stk_ovf, stk_unf, illegal} !== 3'b000) begin
            n_err++; $display("FAIL reset_sticky got %b exp 000", {stk_ovf, stk_unf, illegal});
        end
        rst_n = 1'b1; en = 1'b1;
        drive(C_NEXT, 5'd17);
        cycle();
        n_vec++;
        if (upc !== 5'd17) begin n_err++; $display("FAIL next17 got %0d exp 17", upc); end
        // Asynchronous reset mid-cycle, checked before the next edge.
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (upc !== 5'd0) begin n_err++; $display("FAIL async_reset got %0d exp 0", upc); end
        #1 rst_n = 1'b1;
        drive(C_NEXT, 5'd1);
        cycle();
        n_vec++;
        if (upc !== 5'd1) begin n_err++; $display("FAIL post_reset_next got %0d exp 1", upc); end
    endtask

    task automatic test_dispatch();
        logic [4:0] seq [3];
        seq[0] = 5'd22; seq[1] = 5'd23; seq[2] = 5'd0;
        ctrl = C_DISP; opcode = 5'd21; na = 'x;
        #1;
        n_vec++;
        if (upc_next !== 5'd21) begin n_err++; $display("FAIL disp_next got %0d exp 21", upc_next); end
        cycle();
        n_vec++;
        if (upc !== 5'd21) begin n_err++; $display("FAIL disp_upc got %0d exp 21", upc); end
        for (int i = 0; i < 3; i++) begin
            drive(C_NEXT, seq[i]);
            cycle();
            n_vec++;
            if (upc !== seq[i]) begin n_err++; $display("FAIL disp_seq%0d got %0d exp %0d", i, upc, seq[i]); end
        end
    endtask

    task automatic test_conditional();
        // CDISPATCH true when Z==0 (pol 0): opcode wins.
        drive(C_CDISP, 5'd13); opcode = 5'd10; cond_sel = 2'd0; cond_pol = 1'b0; flags = 4'b0000;
        cycle();
        n_vec++;
        if (upc !== 5'd10) begin n_err++; $display("FAIL cdisp_true got %0d exp 10", upc); end
        flags = 4'b0001;
        cycle();
        n_vec++;
        if (upc !== 5'd13) begin n_err++; $display("FAIL cdisp_false got %0d exp 13", upc); end
        // Select flag 2, polarity 1.
        cond_sel = 2'd2; cond_pol = 1'b1; flags = 4'b0100;
        cycle();
        n_vec++;
        if (upc !== 5'd10) begin n_err++; $display("FAIL cdisp_sel2 got %0d exp 10", upc); end
        drive(C_NEXT, 5'd31);
        cycle();
        // CJUMP false at the top address wraps to 0.
        drive(C_CJUMP, 5'd7); cond_sel = 2'd0; cond_pol = 1'b1; flags = 4'b0000;
        cycle();
        n_vec++;
        if (upc !== 5'd0) begin n_err++; $display("FAIL cjump_wrap got %0d exp 0", upc); end
        flags = 4'b0001;
        cycle();
        n_vec++;
        if (upc !== 5'd7) begin n_err++; $display("FAIL cjump_true got %0d exp 7", upc); end
    endtask

    task automatic test_stack();
        logic [4:0] tgt [5];
        logic [2:0] exp_sp [5];
        tgt[0] = 5'd8;  tgt[1] = 5'd12; tgt[2] = 5'd16; tgt[3] = 5'd24; tgt[4] = 5'd28;
        exp_sp[0] = 3'd1; exp_sp[1] = 3'd2; exp_sp[2] = 3'd3; exp_sp[3] = 3'd4; exp_sp[4] = 3'd4;
        drive(C_NEXT, 5'd5); cycle();
        drive(C_CALL, 5'd20); cycle();
        n_vec++;
        if (upc !== 5'd20 || sp !== 3'd1) begin n_err++; $display("FAIL call got upc %0d sp %0d exp 20 1", upc, sp); end
        drive(C_RET, 5'd0); cycle();
        n_vec++;
        if (upc !== 5'd6 || sp !== 3'd0) begin n_err++; $display("FAIL ret got upc %0d sp %0d exp 6 0", upc, sp); end
        drive(C_NEXT, 5'd9); cycle();
        drive(C_RET, 5'd3); cycle();
        n_vec++;
        if (upc !== 5'd0 || stk_unf !== 1'b1 || sp !== 3'd0) begin
            n_err++; $display("FAIL ret_empty got upc %0d unf %0b sp %0d exp 0 1 0", upc, stk_unf, sp);
        end
        for (int i = 0; i < 5; i++) begin
            drive(C_CALL, tgt[i]); cycle();
            n_vec++;
            if (upc !== tgt[i] || sp !== exp_sp[i]) begin
                n_err++; $display("FAIL call%0d got upc %0d sp %0d exp %0d %0d", i, upc, sp, tgt[i], exp_sp[i]);
            end
        end
        n_vec++;
        if (stk_ovf !== 1'b1 || stk_unf !== 1'b1) begin
            n_err++; $display("FAIL sticky got ovf %0b unf %0b exp 1 1", stk_ovf, stk_unf);
        end
        drive(C_RET, 5'd0); cycle();
        n_vec++;
        if (upc !== 5'd17 || sp !== 3'd3) begin n_err++; $display("FAIL ret_full got upc %0d sp %0d exp 17 3", upc, sp); end
        cycle();
        n_vec++;
        if (upc !== 5'd13 || sp !== 3'd2) begin n_err++; $display("FAIL ret2 got upc %0d sp %0d exp 13 2", upc, sp); end
    endtask

    task automatic test_stall();
        en = 1'b0;
        drive(C_CALL, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (upc_next !== 5'd9) begin n_err++; $display("FAIL stall_next%0d got %0d exp 9", i, upc_next); end
            cycle();
        end
        n_vec++;
        if (upc !== 5'd13 || sp !== 3'd2) begin n_err++; $display("FAIL stall_hold got upc %0d sp %0d exp 13 2", upc, sp); end
        drive(C_RET, 5'd0);
        #1;
        n_vec++;
        if (upc_next !== 5'd9) begin n_err++; $display("FAIL stall_ret_next got %0d exp 9", upc_next); end
        cycle();
        // Abort with en low still flushes.
        abort = 1'b1; cycle(); abort = 1'b0;
        n_vec++;
        if (upc !== 5'd0 || sp !== 3'd0 || {stk_ovf, stk_unf, illegal} !== 3'b000) begin
            n_err++; $display("FAIL abort got upc %0d sp %0d sticky %b exp 0 0 000", upc, sp, {stk_ovf, stk_unf, illegal});
        end
        en = 1'b1;
    endtask

    task automatic test_reserved();
`ifdef MICROSEQ_LOOP_EN
        logic [4:0] exp_l [4];
        exp_l[0] = 5'd4; exp_l[1] = 5'd4; exp_l[2] = 5'd4; exp_l[3] = 5'd5;
        drive(C_NEXT, 5'd3); cycle();
        drive(C_R6, 5'd2); cycle();
        n_vec++;
        if (upc !== exp_l[0]) begin n_err++; $display("FAIL ldcnt got %0d exp 4", upc); end
        for (int i = 1; i < 4; i++) begin
            drive(C_R7, 5'd4); cycle();
            n_vec++;
            if (upc !== exp_l[i]) begin n_err++; $display("FAIL loop%0d got %0d exp %0d", i, upc, exp_l[i]); end
        end
        n_vec++;
        if (illegal !== 1'b0 || sp !== 3'd0) begin n_err++; $display("FAIL loop_side got ill %0b sp %0d exp 0 0", illegal, sp); end
`else
        drive(C_NEXT, 5'd3); cycle();
        drive(C_R6, 5'd12); cycle();
        n_vec++;
        if (upc !== 5'd0 || illegal !== 1'b1) begin n_err++; $display("FAIL rsv110 got upc %0d ill %0b exp 0 1", upc, illegal); end
        drive(C_NEXT, 5'd3); cycle();
        n_vec++;
        if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %0b exp 1", illegal); end
        drive(C_R7, 5'd12); cycle();
        n_vec++;
        if (upc !== 5'd0) begin n_err++; $display("FAIL rsv111 got %0d exp 0", upc); end
        abort = 1'b1; cycle(); abort = 1'b0;
        n_vec++;
        if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear got %0b exp 0", illegal); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [4];
        logic [4:0] nas  [4];
        logic [4:0] eupc [4];
        logic [2:0] esp  [4];
        ops[0] = C_CALL; nas[0] = 5'd10; eupc[0] = 5'd10; esp[0] = 3'd1;
        ops[1] = C_CALL; nas[1] = 5'd20; eupc[1] = 5'd20; esp[1] = 3'd2;
        ops[2] = C_RET;  nas[2] = 5'd0;  eupc[2] = 5'd11; esp[2] = 3'd1;
        ops[3] = C_RET;  nas[3] = 5'd0;  eupc[3] = 5'd6;  esp[3] = 3'd0;
        drive(C_NEXT, 5'd5); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], nas[i]); cycle();
            n_vec++;
            if (upc !== eupc[i] || sp !== esp[i]) begin
                n_err++; $display("FAIL b2b%0d got upc %0d sp %0d exp %0d %0d", i, upc, sp, eupc[i], esp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_conditional();
        test_stack();
        test_stall();
        test_reserved();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
